// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Bytes arrive on the receiver's done pulse, are held in a power-of-two
// circular FIFO and are presented first-word-fall-through to the consumer.
// Bytes arriving while the buffer is full are dropped and counted.
//
// Parameters:
//   DEPTH      byte entries, power of two, >= 2
//   AF_THRESH  almost-full level, 1..DEPTH (only with the option below)
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_tick/wr_data one-cycle byte strobe and byte from the receiver
//   rd_valid/rd_ready/rd_data  consumer handshake, oldest byte on rd_data
//   count/empty/full           occupancy, 0..DEPTH
//   overrun/drop_cnt           sticky drop flag, saturating drop counter
//   overrun_clr                one-cycle clear of overrun and drop_cnt
//   almost_full                count >= AF_THRESH (only with the option)
//
// Option macro: UART_RX_FIFO_ALMOST_FULL_EN adds AF_THRESH and almost_full
// for RTS flow control. Undefined, neither exists.

module uart_rx_fifo #(
    parameter int DEPTH = 16
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,parameter int AF_THRESH = DEPTH - 2
`endif
   ,localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_tick,
    input  logic [7:0]        wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic [7:0]        drop_cnt
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   ,output logic              almost_full
`endif
);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        DROP_MAX = 8'hFF;

    logic [7:0]        mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;

    logic              full_w;
    logic              valid_w;
    logic              push;
    logic              pop;
    logic              drop;

    assign valid_w = (count_q != '0);
    assign full_w  = (count_q == FULL_CNT);

    // A pop frees a slot in the same cycle, so a full buffer still takes
    // the incoming byte when the consumer is reading.
    assign pop  = valid_w & rd_ready;
    assign push = wr_tick & (~full_w | pop);
    assign drop = wr_tick & full_w & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear wins, leaving exactly one drop.
    always_comb begin
        overrun_d  = overrun_q;
        drop_cnt_d = drop_cnt_q;

        if (drop) begin
            overrun_d = 1'b1;
            if (overrun_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (overrun_clr) begin
            overrun_d  = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overrun_q  <= overrun_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid = valid_w;
    assign rd_data  = valid_w ? mem_q[rd_ptr_q] : 8'h00;
    assign count    = count_q;
    assign empty    = ~valid_w;
    assign full     = full_w;
    assign overrun  = overrun_q;
    assign drop_cnt = drop_cnt_q;

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_CNT = (ADDR_W + 1)'(AF_THRESH);

    assign almost_full = (count_q >= AF_CNT);
`endif

endmodule
